transpose_conv_accumulator: RTL

- Consumer end of the pixel-broadcast multiplier stage: takes one beat of K*K products per input pixel and scatter-adds them into an output-map accumulator. This forms a full (transposed) convolution.
- Input map is N×N. Output map is M×M, where M = N+K-1.
- After all N*N input pixels are accumulated, the block streams the M*M sums out in raster order over a valid/ready handshake. It then returns ready for the next frame.

---
 rtl/transpose_conv_accumulator.sv | 110 +++++++++++
 1 files changed

// File: rtl/transpose_conv_accumulator.sv
// Scatter-add accumulator for a full transposed convolution: each input beat adds
// a KxK product window into an MxM map, which is then drained in raster order.
module transpose_conv_accumulator #(
  parameter int K       = 3,
  parameter int N       = 2,
  parameter int OLEN    = 16,
  parameter int ACC_LEN = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OLEN-1:0]    prod [0:K*K-1],
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_LEN-1:0] out_data,
  output logic               out_last
);

  localparam int M     = N + K - 1;
  localparam int DEPTH = M * M;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RW    = (N > 1) ? $clog2(N) : 1;
  localparam int PW    = (K * K > 1) ? $clog2(K * K) : 1;

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t             state;
  logic [RW-1:0]      in_row;
  logic [RW-1:0]      in_col;
  logic [AW-1:0]      out_idx;
  logic [ACC_LEN-1:0] acc      [0:DEPTH-1];
  logic [ACC_LEN-1:0] acc_next [0:DEPTH-1];
  logic               in_fire;
  logic               out_fire;
  logic               in_end;
  logic [AW-1:0]      addr;
  logic [PW-1:0]      pidx;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign in_end   = (in_row == RW'(N - 1)) && (in_col == RW'(N - 1));
  assign out_data = acc[out_idx];
  assign out_last = out_valid && (out_idx == AW'(DEPTH - 1));

  // The KxK window addresses within one beat never collide, so each entry gets
  // at most one add; clear-on-read is exclusive with accumulation by state.
  always_comb begin
    acc_next = acc;
    addr     = '0;
    pidx     = '0;
    if (in_fire) begin
      for (int unsigned i = 0; i < K; i++) begin
        for (int unsigned j = 0; j < K; j++) begin
          addr = AW'((32'(in_row) + i) * M + 32'(in_col) + j);
          pidx = PW'(i * K + j);
          acc_next[addr] = acc_next[addr] + ACC_LEN'(prod[pidx]);
        end
      end
    end
    if (out_fire) begin
      acc_next[out_idx] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '{default: '0};
      state     <= ACCUM;
      in_row    <= '0;
      in_col    <= '0;
      out_idx   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      acc <= acc_next;
      case (state)
        ACCUM: begin
          if (in_fire) begin
            if (in_col == RW'(N - 1)) begin
              in_col <= '0;
              in_row <= (in_row == RW'(N - 1)) ? '0 : in_row + 1'b1;
            end else begin
              in_col <= in_col + 1'b1;
            end
            if (in_end) begin
              state     <= DRAIN;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (out_last) begin
              out_idx   <= '0;
              state     <= ACCUM;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              out_idx <= out_idx + 1'b1;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
